// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: operand-select codes and
// the per-stage destination tag carried down the shadow pipeline.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      regwrite;
    logic                      load;
  } stage_tag_t;

  // The memory stage holds the younger result, so it beats writeback.
  function automatic fwd_sel_t fwd_select(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_MEM;
    if (hit_w) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow-pipeline tag register; flush loads a bubble (all zeros) instead
// of the incoming tag.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter type T = stage_tag_t
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk) begin
    if (reset || flush) q <= '0;
    else                q <= d;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  regwrite_d,
  input  logic                  load_d,
  input  logic                  pcsrc_e,
  output logic [1:0]            forward_ae,
  output logic [1:0]            forward_be,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  load;
  } e_tag_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  load;
  } tag_t;

  e_tag_t e_d, e_q;
  tag_t   m_d, m_q, w_q;
  logic   lw_stall;
  logic   unused_tag_bits;

  assign e_d = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, regwrite: regwrite_d, load: load_d};
  assign m_d = '{rd: e_q.rd, regwrite: e_q.regwrite, load: e_q.load};
  assign unused_tag_bits = m_q.load ^ w_q.load;

  hazard_stage_reg #(.T(e_tag_t)) u_stage_e (
    .clk(clk), .reset(reset), .flush(flush_e), .d(e_d), .q(e_q)
  );

  hazard_stage_reg #(.T(tag_t)) u_stage_m (
    .clk(clk), .reset(reset), .flush(1'b0), .d(m_d), .q(m_q)
  );

  hazard_stage_reg #(.T(tag_t)) u_stage_w (
    .clk(clk), .reset(reset), .flush(1'b0), .d(m_q), .q(w_q)
  );

  // Everything is forced quiet during reset; a taken branch squashes the
  // stalled instruction anyway, so it overrides the load-use stall.
  always_comb begin
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    lw_stall   = e_q.load && (e_q.rd != '0) && ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
    if (!reset) begin
      forward_ae = fwd_select((e_q.rs1 != '0) && (e_q.rs1 == m_q.rd) && m_q.regwrite,
                              (e_q.rs1 != '0) && (e_q.rs1 == w_q.rd) && w_q.regwrite);
      forward_be = fwd_select((e_q.rs2 != '0) && (e_q.rs2 == m_q.rd) && m_q.regwrite,
                              (e_q.rs2 != '0) && (e_q.rs2 == w_q.rd) && w_q.regwrite);
      stall_f    = lw_stall && !pcsrc_e;
      stall_d    = lw_stall && !pcsrc_e;
      flush_d    = pcsrc_e;
      flush_e    = lw_stall || pcsrc_e;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_d && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed vector table followed by
// randomized traffic against an instruction-level pipeline model.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       regwrite_d, load_d, pcsrc_e;
  logic [1:0] forward_ae, forward_be;
  logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d), .pcsrc_e(pcsrc_e),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Instruction-level model: slot 0 = execute, 1 = memory, 2 = writeback.
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld;
  } instr_t;

  instr_t      pipe[3];
  logic [31:0] stall_model = 0;
  logic [31:0] flush_model = 0;

  function automatic logic [1:0] expFwd(input logic [4:0] r);
    if (reset || r == 5'd0) return 2'b00;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].rw && pipe[s].rd == r) return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic loadUse();
    return pipe[0].ld && pipe[0].rd != 5'd0 && (pipe[0].rd == rs1_d || pipe[0].rd == rs2_d);
  endfunction

  function automatic logic expStall();
    return !reset && loadUse() && !pcsrc_e;
  endfunction

  function automatic logic expFlushD();
    return !reset && pcsrc_e;
  endfunction

  function automatic logic expFlushE();
    return !reset && (loadUse() || pcsrc_e);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) pipe[s] <= '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, ld: 1'b0};
      stall_model <= 0;
      flush_model <= 0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      if (expFlushE()) pipe[0] <= '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, ld: 1'b0};
      else             pipe[0] <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, rw: regwrite_d, ld: load_d};
      if (expStall()  && stall_model != 32'hFFFF_FFFF) stall_model <= stall_model + 1;
      if (expFlushD() && flush_model != 32'hFFFF_FFFF) flush_model <= flush_model + 1;
    end
  end

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, pc;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic rst, input logic [4:0] rs1, rs2, rd, input logic rw, ld, pc,
                        input logic [1:0] fa, fb, input logic sf, sd, fd, fe);
    vecs.push_back('{rst: rst, rs1: rs1, rs2: rs2, rd: rd, rw: rw, ld: ld, pc: pc,
                     fa: fa, fb: fb, sf: sf, sd: sd, fd: fd, fe: fe});
  endtask

  task automatic applyStimulus(input logic rst, input logic [4:0] rs1, rs2, rd,
                               input logic rw, ld, pc);
    @(posedge clk);
    #1;
    reset      = rst;
    rs1_d      = rs1;
    rs2_d      = rs2;
    rd_d       = rd;
    regwrite_d = rw;
    load_d     = ld;
    pcsrc_e    = pc;
  endtask

  task automatic cmp(input string tag, input string sig, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s %s got=%0h want=%0h", tag, sig, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] fa, fb, input logic sf, sd, fd, fe);
    cmp(tag, "forward_ae", {30'd0, forward_ae}, {30'd0, fa});
    cmp(tag, "forward_be", {30'd0, forward_be}, {30'd0, fb});
    cmp(tag, "stall_f",    {31'd0, stall_f},    {31'd0, sf});
    cmp(tag, "stall_d",    {31'd0, stall_d},    {31'd0, sd});
    cmp(tag, "flush_d",    {31'd0, flush_d},    {31'd0, fd});
    cmp(tag, "flush_e",    {31'd0, flush_e},    {31'd0, fe});
`ifdef HAZ_PERF_CNT_EN
    cmp(tag, "stall_cnt", stall_cnt, stall_model);
    cmp(tag, "flush_cnt", flush_cnt, flush_model);
`endif
  endtask

  initial begin
    reset = 1'b1; rs1_d = 0; rs2_d = 0; rd_d = 0;
    regwrite_d = 0; load_d = 0; pcsrc_e = 0;

    //      rst rs1 rs2 rd  rw ld pc   fa     fb     sf sd fd fe
    addRow(1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // reset
    addRow(0, 0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // add x5
    addRow(0, 5, 6, 8,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // reader of x5
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);  // mem forward A
    addRow(0, 0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // add x5
    addRow(0, 1, 2, 9,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // unrelated
    addRow(0, 3, 5, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // x5 as rs2
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);  // wb forward B
    addRow(0, 0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // add x5 (older)
    addRow(0, 0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // add x5 (younger)
    addRow(0, 5, 0, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);  // M beats W
    addRow(0, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // writer of x0
    addRow(0, 0, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // reader of x0
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    addRow(0, 0, 0, 7,  1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // lw x7
    addRow(0, 1, 7, 12, 1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1);  // load-use stall
    addRow(0, 1, 7, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // held, bubble in E
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);  // load result from W
    addRow(0, 0, 0, 0,  1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // lw x0
    addRow(0, 0, 0, 13, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // no stall on x0
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    addRow(0, 0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // add x5
    addRow(0, 5, 5, 14, 1, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1);  // branch taken
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // squashed reader gone
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    addRow(0, 0, 0, 7,  1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // lw x7
    addRow(0, 7, 0, 15, 1, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1);  // branch beats stall
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    addRow(0, 0, 0, 7,  1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // lw x7
    addRow(1, 7, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // reset during stall
    addRow(0, 7, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // clean after reset
    addRow(0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                    vecs[i].rw, vecs[i].ld, vecs[i].pc);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb,
                  vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].fe);
`ifdef HAZ_PERF_CNT_EN
      if (i == 31) begin
        cmp("cnt_after_reset", "stall_cnt", stall_cnt, 32'd0);
        cmp("cnt_after_reset", "flush_cnt", flush_cnt, 32'd0);
      end
`endif
    end

    // Random traffic over a small register set so hazards are frequent.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0));
      @(negedge clk);
      checkOutput("rand", expFwd(pipe[0].rs1), expFwd(pipe[0].rs2),
                  expStall(), expStall(), expFlushD(), expFlushE());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
